hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the in-order RISC-V pipeline. Branches resolve in ID.
- Keeps a scoreboard of in-flight destination registers for NSTAGE downstream stages (stage 1 = EX, stage NSTAGE = WB).
- Generates operand-forwarding selects for ID-stage reads, load-use/branch-operand stalls, a branch flush, and the global freeze for an external stall.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID stage and the hazard controller:
// ID-stage operand/destination info in, pipeline enables, flushes and forward selects out.
interface hazard_ctrl_if #(
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int CW     = 32
);
  localparam int SW = $clog2(NSTAGE + 1);

  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_is_load;
  logic          br_taken;
  logic          ext_stall;

  logic          pc_en;
  logic          if_id_en;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          pipe_en;
  logic [SW-1:0] fwd_a_sel;
  logic [SW-1:0] fwd_b_sel;
  logic [CW-1:0] perf_stall_cnt;
  logic [CW-1:0] perf_flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, br_taken, ext_stall,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en,
           fwd_a_sel, fwd_b_sel, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, br_taken, ext_stall,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en,
           fwd_a_sel, fwd_b_sel, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: destination scoreboard for NSTAGE stages after ID,
// ID-stage forwarding selects, load-use stall, branch flush, external freeze, perf counters.
module hazard_ctrl #(
  parameter int AW       = 5,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int SW = $clog2(NSTAGE + 1);
  localparam int unsigned AVAIL_K = 1 + LOAD_LAT;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } entry_t;

  typedef enum logic [2:0] {
    M_RESET,
    M_FREEZE,
    M_HAZARD,
    M_FLUSH,
    M_RUN
  } mode_e;

  entry_t        sb [1:NSTAGE];
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          found_a;
  logic          found_b;
  logic          wait_a;
  logic          wait_b;
  logic          hz;
  mode_e         mode;

  function automatic logic src_hit(input entry_t e, input logic [AW-1:0] src, input logic used);
    return used && e.v && e.wr && (e.rd == src) && (src != '0);
  endfunction

  // Ascending scan with a found flag keeps only the youngest (smallest k) match.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    wait_a  = 1'b0;
    wait_b  = 1'b0;
    for (int unsigned k = 1; k <= NSTAGE; k++) begin
      if (!found_a && src_hit(sb[k], bus.id_rs1, bus.id_rs1_used)) begin
        found_a = 1'b1;
        sel_a   = SW'(k);
        wait_a  = sb[k].ld && (k < AVAIL_K);
      end
      if (!found_b && src_hit(sb[k], bus.id_rs2, bus.id_rs2_used)) begin
        found_b = 1'b1;
        sel_b   = SW'(k);
        wait_b  = sb[k].ld && (k < AVAIL_K);
      end
    end
    if (wait_a) sel_a = '0;
    if (wait_b) sel_b = '0;
  end

  assign hz = bus.id_valid && !bus.ext_stall && (wait_a || wait_b);

  always_comb begin
    if (!rst)               mode = M_RESET;
    else if (bus.ext_stall) mode = M_FREEZE;
    else if (hz)            mode = M_HAZARD;
    else if (bus.br_taken)  mode = M_FLUSH;
    else                    mode = M_RUN;
  end

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.if_id_en    = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.pipe_en     = 1'b0;
    case (mode)
      M_HAZARD: begin
        bus.pipe_en     = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
      M_FLUSH: begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.pipe_en     = 1'b1;
        bus.if_id_flush = 1'b1;
      end
      M_RUN: begin
        bus.pc_en    = 1'b1;
        bus.if_id_en = 1'b1;
        bus.pipe_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fwd_a_sel      = (mode == M_RESET) ? '0 : sel_a;
  assign bus.fwd_b_sel      = (mode == M_RESET) ? '0 : sel_b;
  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;

  // Only the valid bits need reset; stale rd/wr/ld behind v=0 never match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 1; k <= NSTAGE; k++) sb[k].v <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode != M_FREEZE) begin
        for (int unsigned k = 2; k <= NSTAGE; k++) sb[k] <= sb[k-1];
        if (mode == M_HAZARD)
          sb[1] <= '0;
        else
          sb[1] <= entry_t'{v: bus.id_valid, rd: bus.id_rd, wr: bus.id_regwrite, ld: bus.id_is_load};
      end
      if (mode == M_HAZARD && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
      if (mode == M_FLUSH  && flush_cnt != '1) flush_cnt <= flush_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (NSTAGE=3, LOAD_LAT=1, CW=4): the driver queues
// hand-computed expectations per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int NSTAGE = 3;
  localparam int CW = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_FL  = 5'b11101;
  localparam logic [4:0] C_HZ  = 5'b00011;
  localparam logic [4:0] C_OFF = 5'b00000;

  typedef struct {
    int         cyc;
    logic [4:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t exp_q[$];

  hazard_ctrl_if #(.AW(AW), .NSTAGE(NSTAGE), .CW(CW)) bus ();

  hazard_ctrl #(.AW(AW), .NSTAGE(NSTAGE), .LOAD_LAT(1), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input int cyc, input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.cyc, "ctl{pc,ifen,iffl,exfl,pipe}",
          int'({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.pipe_en}), int'(e.ctl));
      chk(e.cyc, "fwd_a_sel", int'(bus.fwd_a_sel), int'(e.fa));
      chk(e.cyc, "fwd_b_sel", int'(bus.fwd_b_sel), int'(e.fb));
      chk(e.cyc, "perf_stall_cnt", int'(bus.perf_stall_cnt), int'(e.sc));
      chk(e.cyc, "perf_flush_cnt", int'(bus.perf_flush_cnt), int'(e.fc));
    end
  end

  task automatic cyc(input logic r, input logic iv,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic ld,
                     input logic br, input logic ext,
                     input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.id_valid    = iv;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_is_load  = ld;
    bus.br_taken    = br;
    bus.ext_stall   = ext;
    e.cyc = cyc_no;
    e.ctl = ctl;
    e.fa  = fa;
    e.fb  = fb;
    e.sc  = sc;
    e.fc  = fc;
    exp_q.push_back(e);
    cyc_no++;
  endtask

  initial begin
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd = '0;
    bus.id_regwrite = 1'b0; bus.id_is_load = 1'b0; bus.br_taken = 1'b0; bus.ext_stall = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    cyc(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, C_OFF, 0, 0, 0, 0);
    // addi x5 ; add x6,x5,x5
    cyc(1, 1, 0, 0, 1, 0,  5, 1, 0, 0, 0, C_RUN, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 1, 1,  6, 1, 0, 0, 0, C_RUN, 1, 1, 0, 0);
    // lw x7 ; add x8,x7,x0 -> one stall then fwd from stage 2
    cyc(1, 1, 0, 0, 1, 0,  7, 1, 1, 0, 0, C_RUN, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 1, 1,  8, 1, 0, 0, 0, C_HZ,  0, 0, 0, 0);
    cyc(1, 1, 7, 0, 1, 1,  8, 1, 0, 0, 0, C_RUN, 2, 0, 1, 0);
    // lw x7 ; beq x7,x0 taken -> stall beats branch, flush next cycle
    cyc(1, 1, 0, 0, 1, 0,  7, 1, 1, 0, 0, C_RUN, 0, 0, 1, 0);
    cyc(1, 1, 7, 0, 1, 1,  0, 0, 0, 1, 0, C_HZ,  0, 0, 1, 0);
    cyc(1, 1, 7, 0, 1, 1,  0, 0, 0, 1, 0, C_FL,  2, 0, 2, 0);
    // three writes to x0, then read x0 from all stages
    cyc(1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0, C_RUN, 0, 0, 2, 1);
    cyc(1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0, C_RUN, 0, 0, 2, 1);
    cyc(1, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0, C_RUN, 0, 0, 2, 1);
    cyc(1, 1, 0, 0, 1, 1, 10, 1, 0, 0, 0, C_RUN, 0, 0, 2, 1);
    // x10 in stages 1 and 3 -> youngest wins
    cyc(1, 1, 0, 0, 1, 0, 11, 1, 0, 0, 0, C_RUN, 0, 0, 2, 1);
    cyc(1, 1,10, 0, 1, 0, 10, 1, 0, 0, 0, C_RUN, 2, 0, 2, 1);
    cyc(1, 1,10,10, 1, 1, 12, 1, 0, 0, 0, C_RUN, 1, 1, 2, 1);
    // ext_stall for 4 cycles over a pending load-use hazard
    cyc(1, 1, 0, 0, 1, 0, 13, 1, 1, 0, 0, C_RUN, 0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 0, 1, C_OFF, 0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 0, 1, C_OFF, 0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 1, 1, C_OFF, 0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 0, 1, C_OFF, 0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 0, 0, C_HZ,  0, 0, 2, 1);
    cyc(1, 1,13,13, 1, 1, 14, 1, 0, 0, 0, C_RUN, 2, 2, 3, 1);
    // reset pulse in the middle of a stall
    cyc(1, 1, 0, 0, 1, 0, 15, 1, 1, 0, 0, C_RUN, 0, 0, 3, 1);
    cyc(1, 1,15, 0, 1, 1, 16, 1, 0, 0, 0, C_HZ,  0, 0, 3, 1);
    cyc(0, 1,15, 0, 1, 1, 16, 1, 0, 0, 0, C_OFF, 0, 0, 4, 1);
    cyc(1, 1,15, 0, 1, 1, 16, 1, 0, 0, 0, C_RUN, 0, 0, 0, 0);
    // chain of dependent loads drives the 4-bit stall counter into saturation
    cyc(1, 1, 0, 0, 1, 0, 17, 1, 1, 0, 0, C_RUN, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cyc(1, 1, 17, 0, 1, 0, 17, 1, 1, 0, 0, C_HZ,  0, 0, 4'((i     > 15) ? 15 : i),     0);
      cyc(1, 1, 17, 0, 1, 0, 17, 1, 1, 0, 0, C_RUN, 2, 0, 4'((i + 1 > 15) ? 15 : i + 1), 0);
    end
    cyc(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, C_RUN, 0, 0, 15, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
